// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi frame controller.
// Holds the controller FSM state encoding, symbol/counter widths and the
// default encoder tail length (K-1).
package viterbi_pkg;

  localparam int unsigned SYM_W        = 2;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned DEF_TAIL_LEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/viterbi_ctrl_wdog.sv
// Idle-cycle watchdog used while the controller drains decisions.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_clear       : restart the idle count (a decision arrived)
//   i_enable      : count only while asserted; count is held at zero otherwise
//   o_expire_c    : combinational, high on the TIMEOUT-th consecutive idle cycle
module viterbi_ctrl_wdog
  import viterbi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;

  // cnt_q holds the number of idle cycles already seen before this one
  assign o_expire_c = i_enable && !i_clear && (cnt_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable || i_clear) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + WD_W'(1);
    end
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for a Viterbi decoder: accepts N+TAIL_LEN coded symbols
// per frame, feeds them to the ACS datapath, forwards the first N survivor
// decisions as decoded bits and drops the tail decisions.
// Ports:
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_start, i_frame_len              : frame start pulse, info bits N
//   i_sym_valid, i_sym, o_sym_ready   : upstream symbol handshake
//   o_acs_valid, o_acs_sym, o_acs_init: ACS datapath drive (1-cycle latency)
//   i_dec_valid, i_dec_bit            : decisions from survivor memory
//   o_bit_valid, o_bit                : decoded bits (combinational pass-through)
//   o_busy, o_frame_done, o_err       : status
// Optional feature (macro VITERBI_CTRL_STATS_EN): adds saturating counters
//   o_frame_cnt (16b) and o_err_cnt (8b).
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned TAIL_LEN = DEF_TAIL_LEN,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_frame_len,
  input  logic             i_sym_valid,
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_sym_ready,
  output logic             o_acs_valid,
  output logic [SYM_W-1:0] o_acs_sym,
  output logic             o_acs_init,
  input  logic             i_dec_valid,
  input  logic             i_dec_bit,
  output logic             o_bit_valid,
  output logic             o_bit,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_err
`ifdef VITERBI_CTRL_STATS_EN
  ,
  output logic [15:0]      o_frame_cnt,
  output logic [7:0]       o_err_cnt
`endif
);

  state_e           state_q;
  logic [7:0]       n_q;
  logic [CNT_W-1:0] sym_cnt_q;
  logic [CNT_W-1:0] dec_cnt_q;
  logic [CNT_W-1:0] dec_cnt_d;
  logic             sym_ready_q;
  logic             acs_valid_q;
  logic [SYM_W-1:0] acs_sym_q;
  logic             acs_init_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             err_q;

  logic [CNT_W-1:0] total_c;
  logic             sym_take_c;
  logic             dec_active_c;
  logic             dec_take_c;
  logic             wdog_expire_c;

  assign total_c      = CNT_W'(n_q) + CNT_W'(TAIL_LEN);
  assign sym_take_c   = i_sym_valid && sym_ready_q;
  // Decisions count from RUN onward; anything beyond the frame total is dropped
  assign dec_active_c = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
  assign dec_take_c   = i_dec_valid && dec_active_c && (dec_cnt_q != total_c);
  assign dec_cnt_d    = dec_cnt_q + CNT_W'(dec_take_c);

  // Only the first N decisions are info bits; the tail ones are discarded
  assign o_bit_valid  = dec_take_c && (dec_cnt_q < CNT_W'(n_q));
  assign o_bit        = o_bit_valid & i_dec_bit;

  assign o_sym_ready  = sym_ready_q;
  assign o_acs_valid  = acs_valid_q;
  assign o_acs_sym    = acs_sym_q;
  assign o_acs_init   = acs_init_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

  viterbi_ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (i_dec_valid),
    .i_enable   (state_q == ST_DRAIN),
    .o_expire_c (wdog_expire_c)
  );

  // Frame FSM, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      sym_cnt_q    <= '0;
      dec_cnt_q    <= '0;
      sym_ready_q  <= 1'b0;
      acs_valid_q  <= 1'b0;
      acs_sym_q    <= '0;
      acs_init_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      acs_valid_q  <= sym_take_c;
      acs_init_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      dec_cnt_q    <= dec_cnt_d;
      if (sym_take_c) begin
        acs_sym_q <= i_sym;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_frame_len == 8'd0) begin
              err_q <= 1'b1;
            end else begin
              n_q        <= i_frame_len;
              sym_cnt_q  <= '0;
              dec_cnt_q  <= '0;
              acs_init_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          sym_ready_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (sym_take_c) begin
            sym_cnt_q <= sym_cnt_q + CNT_W'(1);
            // Drop ready together with the last accept so no extra symbol slips in
            if (sym_cnt_q == total_c - CNT_W'(1)) begin
              sym_ready_q <= 1'b0;
              state_q     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dec_cnt_d == total_c) begin
            state_q <= ST_DONE;
          end else if (wdog_expire_c) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VITERBI_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Saturating event counters, bumped while the matching pulse is visible
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_done_q && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != '1))          err_cnt_q   <= err_cnt_q + 8'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: directed frames plus randomized
// frames, every cycle compared against an event-level frame model.
module tb_viterbi_frame_ctrl;

  localparam int unsigned TAIL = 2;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_sym_valid, i_dec_valid, i_dec_bit;
  logic [7:0] i_frame_len;
  logic [1:0] i_sym;
  logic       o_sym_ready, o_acs_valid, o_acs_init, o_bit_valid, o_bit;
  logic       o_busy, o_frame_done, o_err;
  logic [1:0] o_acs_sym;
`ifdef VITERBI_CTRL_STATS_EN
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;
`endif

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.TAIL_LEN(TAIL), .TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_frame_len  (i_frame_len),
    .i_sym_valid  (i_sym_valid),
    .i_sym        (i_sym),
    .o_sym_ready  (o_sym_ready),
    .o_acs_valid  (o_acs_valid),
    .o_acs_sym    (o_acs_sym),
    .o_acs_init   (o_acs_init),
    .i_dec_valid  (i_dec_valid),
    .i_dec_bit    (i_dec_bit),
    .o_bit_valid  (o_bit_valid),
    .o_bit        (o_bit),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
`ifdef VITERBI_CTRL_STATS_EN
    ,
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: relative cycle m_r counts from the accepted start (INIT is r=1)
  bit         m_on = 0;
  int         m_r = 0, m_n = 0, m_tot = 0, m_acc = 0, m_dec = 0, m_idle = 0, m_done_r = -1;
  bit         p_acs_v = 0, p_err = 0, p_done = 0;
  logic [1:0] p_acs_s = '0;
  int         m_fcnt = 0, m_ecnt = 0;

  // Observations per frame
  int          obs_acs, obs_err, obs_done, obs_nbits;
  logic [31:0] obs_bits;

  task automatic clear_obs();
    obs_acs = 0; obs_err = 0; obs_done = 0; obs_nbits = 0; obs_bits = '0;
  endtask

  task automatic drive_idle();
    i_rst = 0; i_start = 0; i_frame_len = 8'd0; i_sym_valid = 0; i_sym = 2'($urandom);
    i_dec_valid = 0; i_dec_bit = 0;
    if (!m_on && ($urandom_range(0, 7) == 0)) begin
      i_dec_valid = 1; i_dec_bit = 1'($urandom);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the next edge
  task automatic step();
    bit e_ready, e_init, e_busy, take_dec, e_bitv, in_drain, do_acc;
    #1;
    e_busy   = m_on;
    e_init   = m_on && (m_r == 1);
    e_ready  = m_on && (m_r >= 2) && (m_acc < m_tot);
    in_drain = m_on && (m_r >= 2) && (m_acc == m_tot) && (m_done_r < 0);
    take_dec = m_on && (m_r >= 2) && i_dec_valid && (m_dec < m_tot);
    e_bitv   = take_dec && (m_dec < m_n);

    check("busy", o_busy, e_busy);
    check("acs_init", o_acs_init, e_init);
    check("sym_ready", o_sym_ready, e_ready);
    check("acs_valid", o_acs_valid, p_acs_v);
    if (p_acs_v) check("acs_sym", o_acs_sym, p_acs_s);
    check("bit_valid", o_bit_valid, e_bitv);
    check("bit", o_bit, e_bitv ? i_dec_bit : 1'b0);
    check("frame_done", o_frame_done, p_done);
    check("err", o_err, p_err);
`ifdef VITERBI_CTRL_STATS_EN
    check("frame_cnt", o_frame_cnt, m_fcnt);
    check("err_cnt", o_err_cnt, m_ecnt);
`endif
    if (o_acs_valid) obs_acs++;
    if (o_err) obs_err++;
    if (o_frame_done) obs_done++;
    if (o_bit_valid) begin
      if (obs_nbits < 32) obs_bits[obs_nbits] = o_bit;
      obs_nbits++;
    end

    if (p_done && m_fcnt < 65535) m_fcnt++;
    if (p_err && m_ecnt < 255) m_ecnt++;
    do_acc  = e_ready && i_sym_valid;
    p_acs_v = do_acc;
    p_acs_s = i_sym;
    p_err   = 0;
    p_done  = 0;
    if (do_acc) m_acc++;
    if (take_dec) m_dec++;
    if (m_on) begin
      if (m_r == m_done_r) begin
        m_on = 0; p_done = 1;
      end else if (in_drain) begin
        if (m_dec == m_tot) m_done_r = m_r + 1;
        else begin
          m_idle = i_dec_valid ? 0 : m_idle + 1;
          if (m_idle == TMO) begin p_err = 1; m_done_r = m_r + 1; end
        end
      end
      m_r++;
    end else if (i_start) begin
      if (i_frame_len == 8'd0) p_err = 1;
      else begin
        m_on = 1; m_r = 1; m_n = int'(i_frame_len); m_tot = m_n + TAIL;
        m_acc = 0; m_dec = 0; m_idle = 0; m_done_r = -1;
      end
    end
    if (i_rst) begin
      m_on = 0; m_r = 0; p_acs_v = 0; p_err = 0; p_done = 0; m_fcnt = 0; m_ecnt = 0;
    end
  endtask

  // One frame: sym_mode 0=back-to-back, 1=every other cycle, 2=random
  task automatic run_frame(input int n, input int sym_mode, input int dec_budget, input int dec_pct,
                           input logic [31:0] dec_pat, input bit use_pat, input int abort_acc,
                           input bit restart);
    int given = 0;
    int cyc = 0;
    bit aborted = 0;
    clear_obs();
    @(negedge clk);
    drive_idle();
    i_start = 1; i_frame_len = 8'(n);
    step();
    while (m_on && cyc < 2000) begin
      @(negedge clk);
      drive_idle();
      case (sym_mode)
        0:       i_sym_valid = 1;
        1:       i_sym_valid = (cyc % 2 == 0);
        default: i_sym_valid = 1'($urandom);
      endcase
      if (m_r >= 2 && given < dec_budget && $urandom_range(0, 99) < dec_pct) begin
        i_dec_valid = 1;
        i_dec_bit   = (use_pat && given < 32) ? dec_pat[given] : 1'($urandom);
        given++;
      end
      if (restart && m_r == 3) begin i_start = 1; i_frame_len = 8'(n + 3); end
      if (abort_acc > 0 && m_acc == abort_acc && !aborted) begin
        i_rst = 1; i_sym_valid = 0; i_dec_valid = 0; aborted = 1;
      end
      step();
      cyc++;
    end
    check("frame_bounded", 32'(cyc < 2000), 1);
    @(negedge clk);
    drive_idle();
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, tot, budget;
    drive_idle();
    i_dec_valid = 0;
    i_rst = 1;
    repeat (3) begin
      @(negedge clk);
      drive_idle();
      i_rst = 1; i_dec_valid = 0;
      step();
    end

    // N=4 back-to-back, decisions 1,0,1,1,0,1
    run_frame(4, 0, 6, 100, 32'b101101, 1, 0, 0);
    check("bits_n4_count", obs_nbits, 4);
    check("bits_n4_value", obs_bits[3:0], 4'b1101);
    check("n4_done", obs_done, 1);
    check("n4_err", obs_err, 0);

    // Zero-length start
    run_frame(0, 0, 0, 0, '0, 0, 0, 0);
    check("zero_len_err", obs_err, 1);
    check("zero_len_done", obs_done, 0);

    // N=3 with symbols every other cycle
    run_frame(3, 1, 5, 100, '0, 0, 0, 0);
    check("toggle_acs_count", obs_acs, 5);

    // N=2 with one decision missing -> timeout
    run_frame(2, 0, 3, 100, '0, 0, 0, 0);
    check("timeout_err", obs_err, 1);
    check("timeout_done", obs_done, 1);

    // Reset after two symbols, then a clean N=1 frame
    run_frame(5, 0, 7, 50, '0, 0, 2, 0);
    check("abort_done", obs_done, 0);
    check("abort_err", obs_err, 0);
    run_frame(1, 0, 3, 100, '0, 0, 0, 0);
    check("after_abort_done", obs_done, 1);
    check("after_abort_bits", obs_nbits, 1);

    // Second start during RUN must not change N
    run_frame(4, 2, 6, 60, '0, 0, 0, 1);
    check("restart_bits", obs_nbits, 4);
    check("restart_done", obs_done, 1);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      n   = $urandom_range(1, 12);
      tot = n + TAIL;
      if ($urandom_range(0, 3) == 0) budget = tot - $urandom_range(1, 2);
      else                           budget = tot + $urandom_range(0, 3);
      run_frame(n, $urandom_range(0, 2), budget, $urandom_range(30, 100), '0, 0, 0, 0);
      check("rand_bits", obs_nbits, (budget < n) ? budget : n);
      check("rand_err", obs_err, (budget < tot) ? 1 : 0);
      check("rand_done", obs_done, 1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        drive_idle();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
